fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage directly upstream of `inst_rom`. It owns the program counter, drives `PC_addr` into the ROM, and captures the returned 32-bit word into an instruction register for the decode stage. It resolves unconditional jumps locally, accepts redirects from later stages, and supports a decode-side stall. A self-targeting jump is treated as halt.

## Interface
Parameters:
- `ADDR_W`, 8: PC / ROM address width.
- `DATA_W`, 32: instruction width.
- `OPC_JMP`, 8'h08: value of `instruction[31:24]` that marks a jump. The jump target is `instruction[23:16]`.

Ports:
- `clk`  in  1  single clock. All state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  decode cannot accept; hold PC and IR.
- `redirect_valid`  in  1  later stage forces a new PC.
- `redirect_addr`  in  ADDR_W  redirect target.
- `PC_addr`  out  ADDR_W  address to `inst_rom`. Driven combinationally equal to the PC register.
- `instruction`  in  DATA_W  word returned combinationally by `inst_rom`.
- `ir`  out  DATA_W  registered instruction to decode.
- `ir_pc`  out  ADDR_W  address `ir` was fetched from.
- `ir_valid`  out  1  `ir` holds a live instruction.
- `halted`  out  1  fetch stopped on a self-jump.

## Operation
- States: RUN, HALT.
- Reset values: pc=0, `ir`=0, `ir_pc`=0, `ir_valid`=0, `halted`=0, state=RUN.
- Priority per edge: `rst` > `redirect_valid` > HALT > `stall` > normal fetch.
- **Redirect:**
  - pc ← `redirect_addr`, `ir_valid` ← 0, `ir`/`ir_pc` held.
  - State ← RUN, `halted` ← 0.
  - This applies in any state and regardless of `stall`.
- **HALT:** pc, `ir`, `ir_pc` held; `ir_valid` ← 0; `halted`=1.
- **RUN with `stall`=1:** pc, `ir`, `ir_pc`, `ir_valid` all held.
- **RUN, normal fetch:** `ir` ← `instruction`, `ir_pc` ← pc, `ir_valid` ← 1. Then:
  - If `instruction[31:24]==OPC_JMP` and `instruction[23:16]==pc`: pc held, state ← HALT, `halted` ← 1.
  - Else if `instruction[31:24]==OPC_JMP`: pc ← `instruction[23:16]`. No bubble; the jump word itself is still passed to decode with `ir_valid`=1.
  - Else pc ← pc+1, modulo 2^ADDR_W (255 wraps to 0).
- The ROM decodes only `PC_addr[4:0]`, so pc 32..255 alias onto ROM entries 0..31. Fetch does not trap this; pc still increments over the full 8 bits.

## Timing
- `PC_addr` has zero latency from the pc register.
- Fetch-to-IR latency is 1 cycle: the word at pc appears on `ir` after the next rising edge.
- The first `ir_valid` occurs on the first edge after `rst` deasserts, with `ir_pc`=0.
- Redirect costs one bubble: `ir_valid`=0 for one cycle. The target word is valid on the following edge.
- `halted` rises on the same edge that loads the self-jump into `ir`. `ir_valid` drops on the next edge.
- `rst` asserted mid-operation, including mid-stall or in HALT, clears all state immediately (asynchronous).

## Structure
- Shared package `cpu_pkg` holds:
  - `ADDR_W` and `DATA_W`.
  - `OPC_JMP`.
  - Field positions: opcode [31:24], jump target [23:16].
  - The fetch-state enum {RUN, HALT}.
- One combinational sub-module is natural: `next_pc_logic`. Inputs are pc, `instruction`, and the redirect inputs; outputs are next_pc and is_self_jump.
- The state register and IR live in `fetch_unit`.

## Test plan
The bench instantiates `inst_rom` with its stock contents: word 0 = 0x00000000, word 1 = 0x00010001, words 2..27 alternate 0x02000001/0x02010001, word 28 = 0x081C0001.

- **Reset then free-run:** edge 1 gives `ir`=0x00000000, `ir_pc`=0, `ir_valid`=1. Edge 2 gives `ir`=0x00010001, `ir_pc`=1. Edge 3 gives `ir`=0x02000001.
- **Run to halt:** edge 29 gives `ir`=0x081C0001, `ir_pc`=0x1C, `halted`=1, `PC_addr` stays 0x1C. Edge 30 gives `ir_valid`=0. Thereafter everything is stable for 10+ cycles.
- **Stall:** assert `stall` for 3 cycles with `PC_addr`=5. `PC_addr`, `ir`, `ir_pc`=4, and `ir_valid` are all unchanged. One edge after release, `ir_pc`=5.
- **Redirect out of HALT while stalled:** `stall`=1 and `redirect_valid`=1 with `redirect_addr`=0x03. The next edge gives `PC_addr`=3, `halted`=0, `ir_valid`=0. The edge after (stall released) gives `ir`=0x02010001, `ir_pc`=3.
- **Wrap:** redirect to 0xFF. The next edge gives `ir_pc`=0xFF, `ir`=ROM[31]=0x00000000, `PC_addr`=0x00.
- **Asynchronous reset mid-run:** assert `rst` between edges at pc=10. `PC_addr`=0, `ir_valid`=0, and `ir`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, jump opcode, instruction field positions and fetch states.
package cpu_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  localparam logic [7:0] OPC_JMP = 8'h08;

  // Instruction field positions
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 24;
  localparam int unsigned TGT_MSB = 23;
  localparam int unsigned TGT_LSB = 16;

  typedef enum logic {
    RUN,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: redirect, local jump, self-jump hold, or sequential increment.
module next_pc_logic #(
  parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
  parameter int unsigned DATA_W  = cpu_pkg::DATA_W,
  parameter logic [7:0]  OPC_JMP = cpu_pkg::OPC_JMP
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instruction,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] next_pc,
  output logic              is_self_jump
);
  import cpu_pkg::*;

  logic              is_jump;
  logic [ADDR_W-1:0] jump_target;
  logic              unused_low_bits;

  assign is_jump         = (instruction[OPC_MSB:OPC_LSB] == OPC_JMP);
  assign jump_target     = ADDR_W'(instruction[TGT_MSB:TGT_LSB]);
  assign is_self_jump    = is_jump && (jump_target == pc);
  // Operand bits below the jump target play no part in fetch
  assign unused_low_bits = ^instruction[TGT_LSB-1:0];

  // Pick the next PC; a self-jump holds pc so the halted loop does not advance
  always_comb begin
    next_pc = pc + ADDR_W'(1);
    if (redirect_valid) begin
      next_pc = redirect_addr;
    end else if (is_self_jump) begin
      next_pc = pc;
    end else if (is_jump) begin
      next_pc = jump_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures ROM words into the IR, halts on a self-jump.
module fetch_unit #(
  parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
  parameter int unsigned DATA_W  = cpu_pkg::DATA_W,
  parameter logic [7:0]  OPC_JMP = cpu_pkg::OPC_JMP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] PC_addr,
  input  logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic              halted
);
  import cpu_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic [ADDR_W-1:0] next_pc;
  logic              is_self_jump;

  next_pc_logic #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .OPC_JMP(OPC_JMP)
  ) u_next_pc_logic (
    .pc            (pc_q),
    .instruction   (instruction),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .next_pc       (next_pc),
    .is_self_jump  (is_self_jump)
  );

  // Next-state: redirect beats halt, halt beats stall, stall beats a normal fetch
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    if (redirect_valid) begin
      // Target word is not fetched yet, so the IR goes invalid for one bubble
      pc_d       = next_pc;
      ir_valid_d = 1'b0;
      state_d    = RUN;
    end else if (state_q == HALT) begin
      ir_valid_d = 1'b0;
    end else if (!stall) begin
      ir_d       = instruction;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
      pc_d       = next_pc;
      if (is_self_jump) begin
        state_d = HALT;
      end
    end
  end

  // State, PC and IR registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign PC_addr  = pc_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;
  assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: ROM model, behavioural reference, directed and random phases.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic [7:0]  PC_addr;
  logic [31:0] instruction;
  logic [31:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        halted;

  logic [31:0] rom [32];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  m_pc;
  logic [31:0] m_ir;
  logic [7:0]  m_ir_pc;
  logic        m_valid;
  logic        m_halt;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .PC_addr       (PC_addr),
    .instruction   (instruction),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .halted        (halted)
  );

  // ROM decodes only the low five address bits
  assign instruction = rom[PC_addr[4:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_stock_rom();
    rom[0] = 32'h0000_0000;
    rom[1] = 32'h0001_0001;
    for (int i = 2; i < 28; i++) rom[i] = (i % 2 == 0) ? 32'h0200_0001 : 32'h0201_0001;
    rom[28] = 32'h081C_0001;
    for (int i = 29; i < 32; i++) rom[i] = 32'h0000_0000;
  endtask

  // Reference model: applies the fetch rules directly to architectural values
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc    <= 8'd0;
      m_ir    <= 32'd0;
      m_ir_pc <= 8'd0;
      m_valid <= 1'b0;
      m_halt  <= 1'b0;
    end else if (redirect_valid) begin
      m_pc    <= redirect_addr;
      m_valid <= 1'b0;
      m_halt  <= 1'b0;
    end else if (m_halt) begin
      m_valid <= 1'b0;
    end else if (!stall) begin
      m_ir    <= rom[m_pc[4:0]];
      m_ir_pc <= m_pc;
      m_valid <= 1'b1;
      if (rom[m_pc[4:0]][31:24] == 8'h08) begin
        if (rom[m_pc[4:0]][23:16] == m_pc) m_halt <= 1'b1;
        else m_pc <= rom[m_pc[4:0]][23:16];
      end else begin
        m_pc <= m_pc + 8'd1;
      end
    end
  end

  // Compare process: every falling edge, DUT against the model
  always @(negedge clk) begin
    check("cmp_pc_addr", {24'd0, PC_addr}, {24'd0, m_pc});
    check("cmp_ir", ir, m_ir);
    check("cmp_ir_pc", {24'd0, ir_pc}, {24'd0, m_ir_pc});
    check("cmp_ir_valid", {31'd0, ir_valid}, {31'd0, m_valid});
    check("cmp_halted", {31'd0, halted}, {31'd0, m_halt});
  end

  initial begin
    load_stock_rom();
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 8'd0;
    #1;
    check("reset_pc", {24'd0, PC_addr}, 32'd0);
    check("reset_ir", ir, 32'd0);
    check("reset_valid", {31'd0, ir_valid}, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);
    #12;
    rst = 1'b0;

    // Free-run from reset
    edge_step();
    check("e1_ir", ir, 32'h0000_0000);
    check("e1_ir_pc", {24'd0, ir_pc}, 32'd0);
    check("e1_valid", {31'd0, ir_valid}, 32'd1);
    edge_step();
    check("e2_ir", ir, 32'h0001_0001);
    check("e2_ir_pc", {24'd0, ir_pc}, 32'd1);
    edge_step();
    check("e3_ir", ir, 32'h0200_0001);

    // Run to the self-jump at 0x1C
    for (int e = 4; e <= 29; e++) edge_step();
    check("e29_ir", ir, 32'h081C_0001);
    check("e29_ir_pc", {24'd0, ir_pc}, 32'h1C);
    check("e29_halted", {31'd0, halted}, 32'd1);
    check("e29_pc", {24'd0, PC_addr}, 32'h1C);
    edge_step();
    check("e30_valid", {31'd0, ir_valid}, 32'd0);
    for (int e = 0; e < 12; e++) begin
      edge_step();
      check("halt_pc", {24'd0, PC_addr}, 32'h1C);
      check("halt_ir", ir, 32'h081C_0001);
      check("halt_flag", {31'd0, halted}, 32'd1);
    end

    // Redirect out of HALT while stalled
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 8'h03;
    edge_step();
    check("redir_pc", {24'd0, PC_addr}, 32'd3);
    check("redir_halted", {31'd0, halted}, 32'd0);
    check("redir_valid", {31'd0, ir_valid}, 32'd0);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    edge_step();
    check("redir_tgt_ir", ir, 32'h0201_0001);
    check("redir_tgt_ir_pc", {24'd0, ir_pc}, 32'd3);

    // Stall with PC_addr = 5
    edge_step();
    check("pre_stall_pc", {24'd0, PC_addr}, 32'd5);
    stall = 1'b1;
    for (int e = 0; e < 3; e++) begin
      edge_step();
      check("stall_pc", {24'd0, PC_addr}, 32'd5);
      check("stall_ir", ir, 32'h0200_0001);
      check("stall_ir_pc", {24'd0, ir_pc}, 32'd4);
      check("stall_valid", {31'd0, ir_valid}, 32'd1);
    end
    stall = 1'b0;
    edge_step();
    check("unstall_ir_pc", {24'd0, ir_pc}, 32'd5);

    // PC wrap from 0xFF
    redirect_valid = 1'b1;
    redirect_addr  = 8'hFF;
    edge_step();
    redirect_valid = 1'b0;
    edge_step();
    check("wrap_ir_pc", {24'd0, ir_pc}, 32'hFF);
    check("wrap_ir", ir, 32'h0000_0000);
    check("wrap_pc", {24'd0, PC_addr}, 32'd0);

    // Asynchronous reset mid-run at pc = 10
    redirect_valid = 1'b1;
    redirect_addr  = 8'd7;
    edge_step();
    redirect_valid = 1'b0;
    for (int e = 0; e < 3; e++) edge_step();
    check("pre_rst_pc", {24'd0, PC_addr}, 32'd10);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pc", {24'd0, PC_addr}, 32'd0);
    check("arst_valid", {31'd0, ir_valid}, 32'd0);
    check("arst_ir", ir, 32'd0);

    // Random phase with a ROM holding random jumps
    for (int i = 0; i < 32; i++) begin
      if ($urandom_range(0, 3) == 0) rom[i] = {8'h08, 8'($urandom_range(0, 255)), 16'($urandom)};
      else rom[i] = {8'($urandom_range(0, 7)), 24'($urandom)};
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk);
      #1;
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_addr  = 8'($urandom_range(0, 255));
    end
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
